// File: rtl/spram_pkg.sv
// spram_pkg: shared types and constants for single_port_ram_param.
//   wr_mode_t : dout behaviour on a write access
//   state_t   : clear sequencer states
//   BYTE_W    : width of one byte lane covered by a byte enable
package spram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        WR_READ_FIRST  = 2'd0,
        WR_WRITE_FIRST = 2'd1,
        WR_NO_CHANGE   = 2'd2
    } wr_mode_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/spram_clear_fsm.sv
// spram_clear_fsm: post-reset clear sequencer for single_port_ram_param.
// Walks the clear address from 0 to DEPTH-1, one word per cycle, then
// hands the array over to normal accesses.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, restarts the sequence
//   busy     out  high for the whole clear sequence (registered)
//   clr_we   out  write strobe for the clear word
//   clr_addr out  address currently being cleared
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_CLEAR | zeroing mem[cnt], cnt counts up to DEPTH-1
// ST_READY | clear done, array serves user accesses
module spram_clear_fsm
    import spram_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                busy_d = 1'b0;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/single_port_ram_param.sv
// single_port_ram_param: inferred single-port synchronous RAM with byte
// enables, selectable write/read collision mode, read-valid flag and a
// hardware clear of the whole array after reset.
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   access enable
//   we         in   write enable (qualified by en)
//   be         in   byte enables, be[i] covers din[8i+7:8i]
//   addr       in   word address
//   din        in   write data
//   dout       out  registered read data
//   dout_valid out  one-cycle pulse with new dout
//   busy       out  clear sequence running, accesses ignored
// Build option: define SPRAM_OUT_REG_EN to add an output pipeline register
// (read latency 2 instead of 1).
module single_port_ram_param
    import spram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 6,
    parameter int DEPTH   = 2**ADDR_W,
    parameter int WR_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic                     busy
);

    localparam int NB = DATA_W / BYTE_W;
    localparam logic [1:0] MODE_BITS = WR_MODE[1:0];
    localparam wr_mode_t MODE = wr_mode_t'(MODE_BITS);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    if ((DATA_W % BYTE_W) != 0) begin : g_bad_data_w
        $error("single_port_ram_param: DATA_W must be a multiple of 8");
    end
    if ((DEPTH < 1) || (DEPTH > (1 << ADDR_W))) begin : g_bad_depth
        $error("single_port_ram_param: DEPTH out of range for ADDR_W");
    end
    if ((WR_MODE < 0) || (WR_MODE > 2)) begin : g_bad_mode
        $error("single_port_ram_param: WR_MODE must be 0, 1 or 2");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              busy_w;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    spram_clear_fsm #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_fsm (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy_w),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic              in_range;
    logic              acc;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;

    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign acc      = en & ~busy_w;
    assign rd_word  = in_range ? mem_q[addr] : '0;

    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) merged[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
        end
    end

    // The clear sequencer owns the write port while busy; user writes to
    // addresses beyond DEPTH are dropped here.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_be;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_data = din;
        wr_be   = be;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
            wr_be   = '1;
        end else if (acc && we && in_range) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem_q[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;

    always_comb begin
        dout_d = dout_q;
        dv_d   = 1'b0;
        if (busy_w) begin
            dout_d = '0;
        end else if (en) begin
            if (!we) begin
                dout_d = rd_word;
                dv_d   = 1'b1;
            end else begin
                case (MODE)
                    WR_READ_FIRST: begin
                        dout_d = rd_word;
                        dv_d   = 1'b1;
                    end
                    WR_WRITE_FIRST: begin
                        dout_d = in_range ? merged : '0;
                        dv_d   = 1'b1;
                    end
                    default: begin
                        dout_d = dout_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            dout_q <= dout_d;
            dv_q   <= dv_d;
        end
    end

`ifdef SPRAM_OUT_REG_EN
    logic [DATA_W-1:0] pipe_q, pipe_d;
    logic              pipe_v_q, pipe_v_d;

    always_comb begin
        pipe_d   = busy_w ? '0 : dout_q;
        pipe_v_d = busy_w ? 1'b0 : dv_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q   <= '0;
            pipe_v_q <= 1'b0;
        end else begin
            pipe_q   <= pipe_d;
            pipe_v_q <= pipe_v_d;
        end
    end

    assign dout       = pipe_q;
    assign dout_valid = pipe_v_q;
`else
    assign dout       = dout_q;
    assign dout_valid = dv_q;
`endif

    assign busy = busy_w;

endmodule
